// File: rtl/alu_op_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
// No logic; combinational constants only.
// Not applicable (no handshake in this file).
package alu_op_seq_pkg;

    // Sequencer control state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Default op-code and hold-count widths.
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_LAT_W  = 4;

    // Op code that performs no ALU operation.
    localparam int NOP_CODE = 0;

endpackage

// File: rtl/alu_op_seq_onehot_dec.sv
// Maps op code k to a one-hot select with only bit k-1 set; code 0 gives all zeros.
// Purely combinational, zero latency.
// No handshake; the caller registers the result.
module onehot_dec #(
    parameter  int ADDR_W = 3,
    localparam int OUT_W  = 2**ADDR_W - 1
) (
    input  logic [ADDR_W-1:0] i_code,
    output logic [OUT_W-1:0]  o_sel
);

    // Compare the code against every nonzero value; code 0 matches no bit.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < OUT_W; i++) begin
            o_sel[i] = (i_code == ADDR_W'(i + 1));
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues op codes as a registered one-hot ALU select held for a per-request cycle count.
// Select appears 1 cycle after accept and is held for max(hold_cycles,1) cycles.
// in_ready only when idle or on the last hold cycle, and never while flush is high.
module alu_op_sequencer
    import alu_op_seq_pkg::*;
#(
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int LAT_W  = DEF_LAT_W,
    localparam int OUT_W  = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic [LAT_W-1:0]  hold_cycles,
    input  logic              flush,
    output logic [OUT_W-1:0]  general_output,
    output logic              op_active,
    output logic              done
);

    state_t             r_state;
    logic [LAT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_sel;
    logic               r_nop_done;

    logic [OUT_W-1:0]   w_dec;
    logic               w_last;
    logic               w_accept;
    logic               w_is_nop;
    logic [LAT_W-1:0]   w_hold;

    onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .i_code (address),
        .o_sel  (w_dec)
    );

    // Last cycle of the current hold: the slot where a follow-on op can issue without a gap.
    assign w_last   = (r_state == ST_ACTIVE) && (r_cnt == LAT_W'(1));
    assign in_ready = !flush && ((r_state == ST_IDLE) || w_last);
    assign w_accept = in_valid && in_ready;
    assign w_is_nop = (address == ADDR_W'(NOP_CODE));
    // A zero hold request still occupies the select for one cycle.
    assign w_hold   = (hold_cycles == '0) ? LAT_W'(1) : hold_cycles;

    // FSM, hold counter and registered select; flush overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_nop_done <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_nop_done <= 1'b0;
        end else begin
            r_nop_done <= 1'b0;
            if (w_accept) begin
                if (w_is_nop) begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    r_sel      <= '0;
                    r_nop_done <= 1'b1;
                end else begin
                    r_state <= ST_ACTIVE;
                    r_cnt   <= w_hold;
                    r_sel   <= w_dec;
                end
            end else if (r_state == ST_ACTIVE) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_sel   <= '0;
                end else begin
                    r_cnt <= r_cnt - LAT_W'(1);
                end
            end
        end
    end

    assign general_output = r_sel;
    assign op_active      = (r_state == ST_ACTIVE);
    // Completion comes from registered state; flush only masks it so an aborted op never reports done.
    assign done           = !flush && (w_last || r_nop_done);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] address;
    logic [3:0] hold_cycles;
    logic       flush;
    logic [6:0] general_output;
    logic       op_active;
    logic       done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .address        (address),
        .hold_cycles    (hold_cycles),
        .flush          (flush),
        .general_output (general_output),
        .op_active      (op_active),
        .done           (done)
    );

    // Reference model: the op currently owning the select and how many select cycles remain.
    int  m_code;
    int  m_left;
    bit  m_nop;
    wire m_acc = in_valid && !flush && (m_left <= 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_code <= 0;
            m_left <= 0;
            m_nop  <= 1'b0;
        end else if (flush) begin
            m_code <= 0;
            m_left <= 0;
            m_nop  <= 1'b0;
        end else begin
            m_nop <= m_acc && (address == 3'd0);
            if (m_acc && address != 3'd0) begin
                m_code <= int'(address);
                m_left <= (hold_cycles == 4'd0) ? 1 : int'(hold_cycles);
            end else if (m_acc) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end
        end
    end

    function automatic logic [6:0] sel_of(input int code);
        logic [6:0] one;
        one = 7'd1;
        if (code == 0) return 7'd0;
        return one << (code - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    int dut_dones = 0;
    int mdl_dones = 0;

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("model_sel",   int'(general_output), int'((m_left > 0) ? sel_of(m_code) : 7'd0));
            chk("model_active", int'(op_active), int'(m_left > 0));
            chk("model_ready", int'(in_ready), int'(!flush && m_left <= 1));
            chk("model_done",  int'(done), int'(!flush && (m_left == 1 || m_nop)));
            if (done) dut_dones++;
            if (!flush && (m_left == 1 || m_nop)) mdl_dones++;
        end
    end

    task automatic cyc(input bit v, input logic [2:0] a, input logic [3:0] h, input bit f);
        @(negedge clk);
        in_valid    = v;
        address     = a;
        hold_cycles = h;
        flush       = f;
        #3;
    endtask

    task automatic lit(input string name, input logic [6:0] s, input bit d, input bit act);
        chk({name, "_sel"},    int'(general_output), int'(s));
        chk({name, "_done"},   int'(done), int'(d));
        chk({name, "_active"}, int'(op_active), int'(act));
    endtask

    logic [6:0] tbl [8];

    initial begin
        tbl = '{7'h00, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};
        rst_n = 1'b0; in_valid = 1'b0; address = 3'd0; hold_cycles = 4'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        lit("reset", 7'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("reset_ready", int'(in_ready), 1);
        chk_en = 1'b1;

        // Single op, hold 3.
        cyc(1, 3'd3, 4'd3, 0);
        chk("single_ready", int'(in_ready), 1);
        cyc(0, 3'd0, 4'd0, 0); lit("single_c1", 7'b0000100, 0, 1);
        cyc(0, 3'd0, 4'd0, 0); lit("single_c2", 7'b0000100, 0, 1);
        chk("single_busy_ready", int'(in_ready), 0);
        cyc(0, 3'd0, 4'd0, 0); lit("single_c3", 7'b0000100, 1, 1);
        cyc(0, 3'd0, 4'd0, 0); lit("single_after", 7'b0000000, 0, 0);

        // Hold 0 behaves as hold 1.
        cyc(1, 3'd7, 4'd0, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("hold0_c1", 7'b1000000, 1, 1);
        cyc(0, 3'd0, 4'd0, 0); lit("hold0_after", 7'b0000000, 0, 0);

        // NOP code.
        cyc(1, 3'd0, 4'd5, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("nop_c1", 7'b0000000, 1, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("nop_c2", 7'b0000000, 0, 0);

        // Back-to-back issue with no gap.
        cyc(1, 3'd1, 4'd2, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("b2b_c1", 7'b0000001, 0, 1);
        cyc(1, 3'd2, 4'd1, 0); lit("b2b_c2", 7'b0000001, 1, 1);
        chk("b2b_ready_last", int'(in_ready), 1);
        cyc(0, 3'd0, 4'd0, 0); lit("b2b_c3", 7'b0000010, 1, 1);
        cyc(0, 3'd0, 4'd0, 0); lit("b2b_after", 7'b0000000, 0, 0);

        // Flush mid-op, with a request offered during flush that must be refused.
        cyc(1, 3'd4, 4'd5, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("flush_c1", 7'b0001000, 0, 1);
        cyc(1, 3'd6, 4'd2, 1); lit("flush_c2", 7'b0001000, 0, 1);
        chk("flush_ready", int'(in_ready), 0);
        cyc(0, 3'd0, 4'd0, 0); lit("flush_after", 7'b0000000, 0, 0);

        // Flush on the final hold cycle masks done.
        cyc(1, 3'd4, 4'd2, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("flast_c1", 7'b0001000, 0, 1);
        cyc(0, 3'd0, 4'd0, 1); lit("flast_c2", 7'b0001000, 0, 1);
        cyc(0, 3'd0, 4'd0, 0); lit("flast_after", 7'b0000000, 0, 0);

        // Asynchronous reset in the middle of an op.
        cyc(1, 3'd5, 4'd6, 0);
        cyc(0, 3'd0, 4'd0, 0); lit("rst_pre", 7'b0010000, 0, 1);
        #1 rst_n = 1'b0;
        #1 lit("rst_mid", 7'b0000000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #3 chk("rst_release_ready", int'(in_ready), 1);

        // Every code with hold 1: one select bit and exactly one done per request.
        for (int k = 0; k < 8; k++) begin
            cyc(1, 3'(k), 4'd1, 0);
            cyc(0, 3'd0, 4'd0, 0);
            lit($sformatf("decode%0d", k), tbl[k], 1, k != 0);
        end
        cyc(0, 3'd0, 4'd0, 0); lit("decode_after", 7'b0000000, 0, 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
                $urandom_range(0, 19) == 0);
        end
        cyc(0, 3'd0, 4'd0, 0);
        repeat (20) cyc(0, 3'd0, 4'd0, 0);
        chk("done_count", dut_dones, mdl_dones);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
